// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the tick_gen clock-enable generator.
package tick_gen_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int CNT_W_DEF       = 17;
  localparam int DEFAULT_DIV_DEF = 100000;

  // Channel-index width; a single channel still needs a 1-bit select.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen_if.sv
// Control/status bundle between a tick_gen and the logic that programs it.
interface tick_gen_if
  import tick_gen_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = CNT_W_DEF
);
  localparam int CH_W = ch_width(NCH);

  logic [NCH-1:0]   en;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic             wr_mode;
  logic             sync;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   done;

  modport master (
    output en, wr_en, wr_ch, wr_div, wr_mode, sync,
    input  tick, done
  );

  modport slave (
    input  en, wr_en, wr_ch, wr_div, wr_mode, sync,
    output tick, done
  );
endinterface

// File: rtl/tick_chan.sv
// One tick channel: programmable divider with periodic or one-shot behaviour.
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  input  logic             load_mode,
  input  logic             restart,
  output logic             tick,
  output logic             done
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic             mode;
  logic             active;
  logic             terminal;

  assign active   = en && !done && (div != '0);
  // ">=" rather than "==" so a count left beyond the divisor still wraps.
  assign terminal = (cnt >= div - 1'b1);

  always_ff @(posedge clk_in or posedge clr) begin
    if (clr) begin
      cnt  <= '0;
      div  <= CNT_W'(DEFAULT_DIV);
      mode <= MODE_PERIODIC;
      tick <= 1'b0;
      done <= 1'b0;
    end else begin
      if (load) begin
        div  <= load_div;
        mode <= load_mode;
      end

      if (load || restart) begin
        cnt  <= '0;
        tick <= 1'b0;
        done <= 1'b0;
      end else if (active) begin
        if (terminal) begin
          cnt  <= '0;
          tick <= 1'b1;
          if (mode == MODE_ONESHOT) begin
            done <= 1'b1;
          end
        end else begin
          cnt  <= cnt + 1'b1;
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel clock-enable generator: write decode, sync fan-out, channel array.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic     clk_in,
  input  logic     clr,
  tick_gen_if.slave bus
);

  localparam int CH_W = ch_width(NCH);

  logic [NCH-1:0] load;
  logic [NCH-1:0] tick_w;
  logic [NCH-1:0] done_w;

  // Indices at or above NCH match no channel, so such writes fall away.
  always_comb begin
    load = '0;
    for (int i = 0; i < NCH; i++) begin
      load[i] = bus.wr_en && (bus.wr_ch == CH_W'(i));
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    tick_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in    (clk_in),
      .clr       (clr),
      .en        (bus.en[i]),
      .load      (load[i]),
      .load_div  (bus.wr_div),
      .load_mode (bus.wr_mode),
      .restart   (bus.sync),
      .tick      (tick_w[i]),
      .done      (done_w[i])
    );
  end

  assign bus.tick = tick_w;
  assign bus.done = done_w;

endmodule
